// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are registered onto the ALU, held for EXEC_CYCLES, then the result is captured and returned.
module alu_arbiter #(
  parameter int                 DATA_W      = 32,
  parameter int                 FUNC_W      = 3,
  parameter logic [FUNC_W-1:0]  CMP_FUNC    = 3'b101,
  parameter int                 EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic [1:0]        rsp_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [1:0]        alu_flags,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] exec_cnt;
  // Owner of the most recent grant; it also routes the response pulse.
  logic       last_grant;

  assign req0_ready = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      exec_cnt   <= 4'd0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      rsp_result <= '0;
      rsp_flags  <= 2'b00;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          if (req0_ready) begin
            alu_a      <= req0_a;
            alu_b      <= req0_b;
            alu_func   <= req0_func;
            last_grant <= 1'b0;
            exec_cnt   <= 4'd0;
            state      <= EXEC;
          end else if (req1_ready) begin
            alu_a      <= req1_a;
            alu_b      <= req1_b;
            alu_func   <= req1_func;
            last_grant <= 1'b1;
            exec_cnt   <= 4'd0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          exec_cnt <= exec_cnt + 4'd1;
          if (exec_cnt == LAST_CNT) begin
            rsp_result <= alu_result;
            // Only compares touch the architectural flags.
            if (alu_func == CMP_FUNC) begin
              rsp_flags <= alu_flags;
            end
            rsp0_valid <= !last_grant;
            rsp1_valid <= last_grant;
            state      <= RESP;
          end
        end
        RESP: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, per-requester drivers, a cycle model of the
// arbiter and a scoreboard of expected responses; a second instance runs EXEC_CYCLES=3.
module tb_alu_arbiter;

  localparam int E1 = 1;
  localparam int E3 = 3;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
  } op_t;

  typedef struct {
    bit          owner;
    logic [31:0] res;
    logic [1:0]  flg;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_func, req1_func;
  logic        rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [1:0]  rsp_flags, alu_flags;
  logic [2:0]  alu_func;

  logic        d3_req0_valid, d3_req0_ready, d3_req1_valid, d3_req1_ready;
  logic [31:0] d3_req0_a, d3_req0_b, d3_req1_a, d3_req1_b;
  logic [2:0]  d3_req0_func, d3_req1_func;
  logic        d3_rsp0_valid, d3_rsp1_valid, d3_busy;
  logic [31:0] d3_rsp_result, d3_alu_a, d3_alu_b, d3_alu_result;
  logic [1:0]  d3_rsp_flags, d3_alu_flags;
  logic [2:0]  d3_alu_func;

  // Behavioural ALU: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 CMP (a-b), 6 NOT a, 7 pass b.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f);
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return a - b;
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  function automatic logic [1:0] flags_fn(input logic [31:0] r);
    if (r == 32'd0) return 2'b01;
    if (r[31])      return 2'b10;
    return 2'b00;
  endfunction

  assign alu_result    = alu_fn(alu_a, alu_b, alu_func);
  assign alu_flags     = flags_fn(alu_result);
  assign d3_alu_result = alu_fn(d3_alu_a, d3_alu_b, d3_alu_func);
  assign d3_alu_flags  = flags_fn(d3_alu_result);

  alu_arbiter #(.DATA_W(32), .FUNC_W(3), .CMP_FUNC(3'b101), .EXEC_CYCLES(E1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_func(req1_func),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
  );

  alu_arbiter #(.DATA_W(32), .FUNC_W(3), .CMP_FUNC(3'b101), .EXEC_CYCLES(E3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_a(d3_req0_a),
    .req0_b(d3_req0_b), .req0_func(d3_req0_func),
    .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready), .req1_a(d3_req1_a),
    .req1_b(d3_req1_b), .req1_func(d3_req1_func),
    .rsp0_valid(d3_rsp0_valid), .rsp1_valid(d3_rsp1_valid), .rsp_result(d3_rsp_result),
    .rsp_flags(d3_rsp_flags),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_func(d3_alu_func),
    .alu_result(d3_alu_result), .alu_flags(d3_alu_flags), .busy(d3_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  op_t  q_in0[$];
  op_t  q_in1[$];
  exp_t sb[$];
  exp_t q3[$];
  bit   grant_log[$];
  bit   acc0 = 1'b0;
  bit   acc1 = 1'b0;

  // Cycle model of the arbiter (main instance).
  int         cnt_m  = 0;
  bit         lg_m   = 1'b1;
  logic [1:0] flags_m = 2'b00;
  op_t        held;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester drivers: present the next queued op once the previous one was accepted.
  initial begin
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_func = '0;
    forever begin
      op_t op;
      @(posedge clk); #1;
      if (rst || acc0) begin
        req0_valid = 1'b0;
        acc0 = 1'b0;
      end
      if (!rst && !req0_valid && q_in0.size() > 0) begin
        op = q_in0.pop_front();
        req0_a = op.a; req0_b = op.b; req0_func = op.f; req0_valid = 1'b1;
      end
    end
  end

  initial begin
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_func = '0;
    forever begin
      op_t op;
      @(posedge clk); #1;
      if (rst || acc1) begin
        req1_valid = 1'b0;
        acc1 = 1'b0;
      end
      if (!rst && !req1_valid && q_in1.size() > 0) begin
        op = q_in1.pop_front();
        req1_a = op.a; req1_b = op.b; req1_func = op.f; req1_valid = 1'b1;
      end
    end
  end

  // Monitor / scoreboard for the main instance, sampled on the falling edge.
  initial forever begin
    bit   m0, m1;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      cnt_m = 0; lg_m = 1'b1; flags_m = 2'b00;
      sb.delete();
    end else begin
      m0 = (cnt_m == 0) && req0_valid && (!req1_valid || lg_m);
      m1 = (cnt_m == 0) && req1_valid && (!req0_valid || !lg_m);
      check("req0_ready", 32'(req0_ready), 32'(m0));
      check("req1_ready", 32'(req1_ready), 32'(m1));
      check("busy", 32'(busy), 32'(cnt_m != 0));
      if (cnt_m != 0) begin
        check("alu_a_hold", alu_a, held.a);
        check("alu_b_hold", alu_b, held.b);
        check("alu_func_hold", 32'(alu_func), 32'(held.f));
      end
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          $display("rsp req%0d result=%h flags=%b at cycle %0d", e.owner, rsp_result,
                   rsp_flags, cyc);
          check("rsp0_owner", 32'(rsp0_valid), 32'(!e.owner));
          check("rsp1_owner", 32'(rsp1_valid), 32'(e.owner));
          check("rsp_result", rsp_result, e.res);
          check("rsp_flags", 32'(rsp_flags), 32'(e.flg));
          check("rsp_latency", 32'(cyc - e.cyc), 32'(E1 + 1));
        end
      end else if (cnt_m == 1) begin
        check("rsp_missing", 32'(0), 32'(1));
      end
      if (m0 || m1) begin
        held = m0 ? op_t'{req0_a, req0_b, req0_func} : op_t'{req1_a, req1_b, req1_func};
        lg_m = m1;
        if (m0) acc0 = 1'b1;
        else    acc1 = 1'b1;
        if (held.f == 3'b101) flags_m = flags_fn(alu_fn(held.a, held.b, held.f));
        sb.push_back(exp_t'{m1, alu_fn(held.a, held.b, held.f), flags_m, cyc});
        grant_log.push_back(m1);
        cnt_m = E1 + 1;
      end else if (cnt_m > 0) begin
        cnt_m--;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    q_in0.delete();
    q_in1.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 200 && (q_in0.size() != 0 || q_in1.size() != 0 || sb.size() != 0 ||
                           req0_valid || req1_valid || cnt_m != 0));
    if (n >= 200) check("drain_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_grant(input int target);
    int n = 0;
    while (grant_log.size() < target && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (grant_log.size() < target) check("grant_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_d3();
    int   n = 0;
    int   acc_cyc;
    int   busy_run = 0;
    bit   got = 1'b0;
    exp_t e;
    d3_req0_a = 32'd0; d3_req0_b = 32'd0; d3_req0_func = 3'd6; d3_req0_valid = 1'b1;
    @(negedge clk);
    while (!d3_req0_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("d3_ready", 32'(d3_req0_ready), 32'(1));
    acc_cyc = cyc;
    q3.push_back(exp_t'{1'b0, alu_fn(32'd0, 32'd0, 3'd6), 2'b00, acc_cyc});
    @(posedge clk); #1 d3_req0_valid = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (d3_busy) busy_run++;
      if (d3_rsp0_valid || d3_rsp1_valid) begin
        got = 1'b1;
        e = q3.pop_front();
        $display("d3 rsp req0 result=%h flags=%b at cycle %0d", d3_rsp_result, d3_rsp_flags, cyc);
        check("d3_rsp1_idle", 32'(d3_rsp1_valid), 32'(0));
        check("d3_result", d3_rsp_result, e.res);
        check("d3_latency", 32'(cyc - e.cyc), 32'(E3 + 1));
        check("d3_busy_cycles", 32'(busy_run), 32'(E3 + 1));
      end
    end
    if (!got) check("d3_rsp_timeout", 32'(0), 32'(1));
    @(negedge clk);
    check("d3_busy_after", 32'(d3_busy), 32'(0));
  endtask

  initial begin
    d3_req0_valid = 1'b0; d3_req0_a = '0; d3_req0_b = '0; d3_req0_func = '0;
    d3_req1_valid = 1'b0; d3_req1_a = '0; d3_req1_b = '0; d3_req1_func = '0;
    do_reset();
    @(negedge clk);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_func", 32'(alu_func), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_flags", 32'(rsp_flags), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);

    q_in0.push_back(op_t'{32'd5, 32'd3, 3'd3});
    wait_drain();
    check("single_result", rsp_result, 32'd8);
    check("single_flags", 32'(rsp_flags), 32'd0);

    q_in1.push_back(op_t'{32'd7, 32'd7, 3'd5});
    wait_drain();
    check("cmp_eq_flags", 32'(rsp_flags), 32'(2'b01));
    q_in1.push_back(op_t'{32'd2, 32'd9, 3'd5});
    wait_drain();
    check("cmp_lt_flags", 32'(rsp_flags), 32'(2'b10));
    q_in1.push_back(op_t'{32'd1, 32'd1, 3'd3});
    wait_drain();
    check("add_result", rsp_result, 32'd2);
    check("add_flags_kept", 32'(rsp_flags), 32'(2'b10));

    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      q_in0.push_back(op_t'{32'hF0F0, 32'hFF00, 3'd0});
      q_in1.push_back(op_t'{32'h0F, 32'hF0, 3'd1});
    end
    wait_drain();
    check("contend_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("contend_order", 32'(grant_log[i]), 32'(i % 2));

    grant_log.delete();
    q_in0.push_back(op_t'{32'h1234, 32'h1, 3'd3});
    wait_grant(1);
    q_in1.push_back(op_t'{32'h10, 32'h3, 3'd4});
    wait_drain();
    check("hold_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("hold_first", 32'(grant_log[0]), 32'd0);
      check("hold_second", 32'(grant_log[1]), 32'd1);
    end

    grant_log.delete();
    q_in0.push_back(op_t'{32'd1, 32'd1, 3'd5});
    wait_grant(1);
    @(posedge clk); #1;
    check("midop_busy", 32'(busy), 32'd1);
    do_reset();
    @(negedge clk);
    check("midop_flags", 32'(rsp_flags), 32'd0);
    check("midop_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    grant_log.delete();
    q_in0.push_back(op_t'{32'd4, 32'd4, 3'd3});
    q_in1.push_back(op_t'{32'd6, 32'd6, 3'd3});
    wait_drain();
    check("midop_tie_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) check("midop_tie_winner", 32'(grant_log[0]), 32'd0);

    run_d3();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
